// File: rtl/battle_sequencer.sv
// Turn-based battle controller: HP, cursor, turn order, enemy/end delays, XP award and run handshake.
module battle_sequencer #(
    parameter int unsigned PLAYER_DAMAGE = 20,
    parameter int unsigned ENEMY_DAMAGE  = 10,
    parameter int unsigned PLAYER_MAX_HP = 100,
    parameter int unsigned ENEMY_MAX_HP  = 100,
    parameter int unsigned ENEMY_DELAY   = 20,
    parameter int unsigned END_DELAY     = 15,
    parameter int unsigned XP_GAIN       = 50
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        left_in,
    input  logic        right_in,
    input  logic        up_in,
    input  logic        down_in,
    input  logic        select,
    input  logic [7:0]  health_in,
    input  logic [7:0]  xp_in,
    output logic [7:0]  health_out,
    output logic [7:0]  enemy_health,
    output logic [10:0] player_bar_change,
    output logic [10:0] enemy_bar_change,
    output logic        arrow_col,
    output logic        arrow_row,
    output logic [7:0]  xp_out,
    output logic        run,
    output logic        win,
    output logic [2:0]  state_out
);

    localparam int unsigned HP_W  = 8;
    localparam int unsigned BAR_W = 11;
    localparam int unsigned CNT_W = 8;

    localparam logic [HP_W-1:0]  P_DMG   = HP_W'(PLAYER_DAMAGE);
    localparam logic [HP_W-1:0]  E_DMG   = HP_W'(ENEMY_DAMAGE);
    localparam logic [HP_W-1:0]  P_MAX   = HP_W'(PLAYER_MAX_HP);
    localparam logic [HP_W-1:0]  E_MAX   = HP_W'(ENEMY_MAX_HP);
    localparam logic [CNT_W-1:0] E_DLY   = CNT_W'(ENEMY_DELAY);
    localparam logic [CNT_W-1:0] END_DLY = CNT_W'(END_DELAY);
    localparam logic [BAR_W-1:0] P_BAR   = BAR_W'(PLAYER_DAMAGE / 2);
    localparam logic [BAR_W-1:0] E_BAR   = BAR_W'(ENEMY_DAMAGE / 2);
    localparam logic [HP_W:0]    XP_ADD  = (HP_W + 1)'(XP_GAIN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MENU     = 3'd1,
        P_ATK    = 3'd2,
        E_WAIT   = 3'd3,
        END_WAIT = 3'd4,
        EXIT     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;
    logic [HP_W-1:0]    health_d, enemy_d, xp_d;
    logic [BAR_W-1:0]   pbar_d, ebar_d;
    logic               col_d, row_d, run_d, win_d;

    logic               select_rise;
    logic [HP_W-1:0]    enemy_sub, player_sub, xp_win;
    logic [HP_W:0]      xp_sum;

    // Saturating HP/XP arithmetic and select edge detect against the last tick's sample
    always_comb begin
        select_rise = select & ~sel_q;
        enemy_sub   = (enemy_health > P_DMG) ? (enemy_health - P_DMG) : '0;
        player_sub  = (health_out > E_DMG) ? (health_out - E_DMG) : '0;
        xp_sum      = {1'b0, xp_in} + XP_ADD;
        xp_win      = xp_sum[HP_W] ? '1 : xp_sum[HP_W-1:0];
    end

    // State register and all game-state registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            sel_q             <= 1'b0;
            health_out        <= '0;
            enemy_health      <= '0;
            player_bar_change <= '0;
            enemy_bar_change  <= '0;
            arrow_col         <= 1'b0;
            arrow_row         <= 1'b0;
            xp_out            <= '0;
            run               <= 1'b0;
            win               <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            sel_q             <= sel_d;
            health_out        <= health_d;
            enemy_health      <= enemy_d;
            player_bar_change <= pbar_d;
            enemy_bar_change  <= ebar_d;
            arrow_col         <= col_d;
            arrow_row         <= row_d;
            xp_out            <= xp_d;
            run               <= run_d;
            win               <= win_d;
        end
    end

    // Next-state and game-state update; abort on start low overrides everything
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        health_d = health_out;
        enemy_d  = enemy_health;
        pbar_d   = player_bar_change;
        ebar_d   = enemy_bar_change;
        col_d    = arrow_col;
        row_d    = arrow_row;
        xp_d     = xp_out;
        run_d    = run;
        win_d    = win;

        if (frame_tick) begin
            sel_d = select;
        end

        if (state_q != IDLE && !start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        health_d = (health_in == '0) ? P_MAX : health_in;
                        enemy_d  = E_MAX;
                        pbar_d   = '0;
                        ebar_d   = '0;
                        col_d    = 1'b0;
                        row_d    = 1'b0;
                        xp_d     = xp_in;
                        run_d    = 1'b0;
                        win_d    = 1'b0;
                        state_d  = MENU;
                    end
                end
                MENU: begin
                    if (frame_tick) begin
                        if (left_in)       col_d = 1'b0;
                        else if (right_in) col_d = 1'b1;
                        if (up_in)         row_d = 1'b0;
                        else if (down_in)  row_d = 1'b1;
                        if (select_rise) begin
                            if (!arrow_col && !arrow_row) begin
                                state_d = P_ATK;
                            end else if (arrow_col && arrow_row) begin
                                xp_d    = xp_in;
                                win_d   = 1'b0;
                                run_d   = 1'b1;
                                state_d = EXIT;
                            end
                        end
                    end
                end
                P_ATK: begin
                    if (frame_tick) begin
                        enemy_d = enemy_sub;
                        ebar_d  = enemy_bar_change + P_BAR;
                        if (enemy_sub == '0) begin
                            win_d   = 1'b1;
                            state_d = END_WAIT;
                        end else begin
                            state_d = E_WAIT;
                        end
                    end
                end
                E_WAIT: begin
                    if (frame_tick) begin
                        if (cnt_q == E_DLY) begin
                            health_d = player_sub;
                            pbar_d   = player_bar_change + E_BAR;
                            if (player_sub == '0) begin
                                win_d   = 1'b0;
                                state_d = END_WAIT;
                            end else begin
                                state_d = MENU;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                END_WAIT: begin
                    if (frame_tick) begin
                        if (cnt_q == END_DLY) begin
                            xp_d    = win ? xp_win : xp_in;
                            run_d   = 1'b1;
                            state_d = EXIT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                EXIT: begin
                    state_d = EXIT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Testbench for battle_sequencer: directed battles plus randomized play against a reference model.
module tb_battle_sequencer;

    localparam int PD       = 20;
    localparam int ED       = 10;
    localparam int PMAX     = 100;
    localparam int EMAX     = 100;
    localparam int EDELAY   = 20;
    localparam int ENDDELAY = 15;
    localparam int XPG      = 50;

    localparam int S_IDLE = 0, S_MENU = 1, S_PATK = 2, S_EWAIT = 3, S_END = 4, S_EXIT = 5;

    logic        clk_in;
    logic        rst_n_in;
    logic        start, frame_tick;
    logic        left_in, right_in, up_in, down_in, select;
    logic [7:0]  health_in, xp_in;
    logic [7:0]  health_out, enemy_health, xp_out;
    logic [10:0] player_bar_change, enemy_bar_change;
    logic        arrow_col, arrow_row, run, win;
    logic [2:0]  state_out;

    battle_sequencer dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .start             (start),
        .frame_tick        (frame_tick),
        .left_in           (left_in),
        .right_in          (right_in),
        .up_in             (up_in),
        .down_in           (down_in),
        .select            (select),
        .health_in         (health_in),
        .xp_in             (xp_in),
        .health_out        (health_out),
        .enemy_health      (enemy_health),
        .player_bar_change (player_bar_change),
        .enemy_bar_change  (enemy_bar_change),
        .arrow_col         (arrow_col),
        .arrow_row         (arrow_row),
        .xp_out            (xp_out),
        .run               (run),
        .win               (win),
        .state_out         (state_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int    n_pass  = 0;
    int    n_total = 0;
    string phase   = "init";

    // Reference game state
    int m_state, m_cnt, m_hp, m_ehp, m_pbar, m_ebar, m_xp;
    bit m_col, m_row, m_run, m_win, m_sel_prev;

    function automatic int sat_sub(input int a, input int b);
        return (a > b) ? a - b : 0;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_cnt = 0; m_hp = 0; m_ehp = 0; m_pbar = 0; m_ebar = 0;
        m_xp = 0; m_col = 0; m_row = 0; m_run = 0; m_win = 0; m_sel_prev = 0;
    endtask

    task automatic enter(input int s);
        m_state = s;
        m_cnt   = 0;
    endtask

    // One rising clock edge of the battle rules, using the inputs currently applied
    task automatic model_clock();
        bit rise, c0, r0;
        rise = select && !m_sel_prev;
        c0   = m_col;
        r0   = m_row;
        if (m_state != S_IDLE && !start) begin
            enter(S_IDLE);
        end else if (m_state == S_IDLE) begin
            if (start) begin
                m_hp  = (health_in == 0) ? PMAX : int'(health_in);
                m_ehp = EMAX; m_pbar = 0; m_ebar = 0; m_col = 0; m_row = 0;
                m_xp  = int'(xp_in); m_run = 0; m_win = 0;
                enter(S_MENU);
            end
        end else if (frame_tick) begin
            case (m_state)
                S_MENU: begin
                    if (left_in) m_col = 0; else if (right_in) m_col = 1;
                    if (up_in)   m_row = 0; else if (down_in)  m_row = 1;
                    if (rise && !c0 && !r0) enter(S_PATK);
                    else if (rise && c0 && r0) begin
                        m_xp = int'(xp_in); m_win = 0; m_run = 1;
                        enter(S_EXIT);
                    end
                end
                S_PATK: begin
                    m_ehp  = sat_sub(m_ehp, PD);
                    m_ebar = m_ebar + PD / 2;
                    if (m_ehp == 0) begin m_win = 1; enter(S_END); end
                    else enter(S_EWAIT);
                end
                S_EWAIT: begin
                    if (m_cnt == EDELAY) begin
                        m_hp   = sat_sub(m_hp, ED);
                        m_pbar = m_pbar + ED / 2;
                        if (m_hp == 0) begin m_win = 0; enter(S_END); end
                        else enter(S_MENU);
                    end else m_cnt++;
                end
                S_END: begin
                    if (m_cnt == ENDDELAY) begin
                        m_xp  = m_win ? ((int'(xp_in) + XPG > 255) ? 255 : int'(xp_in) + XPG) : int'(xp_in);
                        m_run = 1;
                        enter(S_EXIT);
                    end else m_cnt++;
                end
                default: ;
            endcase
        end
        if (frame_tick) m_sel_prev = select;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, exp);
    endtask

    task automatic check_all();
        chk("state_out",         32'(state_out),         32'(m_state));
        chk("health_out",        32'(health_out),        32'(m_hp));
        chk("enemy_health",      32'(enemy_health),      32'(m_ehp));
        chk("player_bar_change", 32'(player_bar_change), 32'(m_pbar));
        chk("enemy_bar_change",  32'(enemy_bar_change),  32'(m_ebar));
        chk("arrow_col",         32'(arrow_col),         32'(m_col));
        chk("arrow_row",         32'(arrow_row),         32'(m_row));
        chk("xp_out",            32'(xp_out),            32'(m_xp));
        chk("run",               32'(run),               32'(m_run));
        chk("win",               32'(win),               32'(m_win));
    endtask

    // One clock cycle starting and ending at a falling edge
    task automatic step(input bit tk);
        frame_tick = tk;
        @(posedge clk_in);
        model_clock();
        #1 check_all();
        @(negedge clk_in);
        frame_tick = 1'b0;
    endtask

    // A frame: a few idle cycles, then the tick cycle
    task automatic tick();
        repeat ($urandom_range(0, 2)) step(1'b0);
        step(1'b1);
    endtask

    task automatic buttons(input bit l, input bit r, input bit u, input bit d, input bit s);
        left_in = l; right_in = r; up_in = u; down_in = d; select = s;
    endtask

    task automatic begin_battle(input logic [7:0] hp, input logic [7:0] xp);
        start = 1'b0;
        step(1'b0);
        health_in = hp; xp_in = xp; start = 1'b1;
        step(1'b0);
    endtask

    // Keep choosing FIGHT until the battle reaches EXIT or the tick budget runs out
    task automatic play_to_exit(input int budget);
        int n;
        n = 0;
        while (m_state != S_EXIT && n < budget) begin
            buttons(1, 0, 1, 0, (m_state == S_MENU) && !m_sel_prev);
            tick();
            n++;
        end
        buttons(0, 0, 0, 0, 0);
        chk("exit_reached", 32'(state_out), 32'(S_EXIT));
    endtask

    initial begin
        int p, w, hp_hold;
        rst_n_in = 1'b0; start = 1'b0; frame_tick = 1'b0;
        buttons(0, 0, 0, 0, 0);
        health_in = 8'd0; xp_in = 8'd0;
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        phase = "reset";
        check_all();
        rst_n_in = 1'b1;
        step(1'b0);

        phase = "win";
        begin_battle(8'd100, 8'd10);
        chk("load_state", 32'(state_out), 32'(S_MENU));
        play_to_exit(400);
        chk("win_health", 32'(health_out), 32'd60);
        chk("win_enemy", 32'(enemy_health), 32'd0);
        chk("win_ebar", 32'(enemy_bar_change), 32'd50);
        chk("win_pbar", 32'(player_bar_change), 32'd20);
        chk("win_xp", 32'(xp_out), 32'd60);
        chk("win_flag", 32'(win), 32'd1);
        chk("win_run", 32'(run), 32'd1);
        start = 1'b0;
        step(1'b0);
        chk("run_held_idle", 32'(run), 32'd1);

        phase = "loss";
        begin_battle(8'd15, 8'd200);
        play_to_exit(400);
        chk("loss_health", 32'(health_out), 32'd0);
        chk("loss_pbar", 32'(player_bar_change), 32'd10);
        chk("loss_enemy", 32'(enemy_health), 32'd60);
        chk("loss_win", 32'(win), 32'd0);
        chk("loss_xp", 32'(xp_out), 32'd200);

        phase = "xp_sat";
        begin_battle(8'd0, 8'd230);
        chk("max_hp_load", 32'(health_out), 32'd100);
        play_to_exit(400);
        chk("xp_sat", 32'(xp_out), 32'd255);

        phase = "run_opt";
        begin_battle(8'd77, 8'd33);
        buttons(0, 1, 0, 0, 0); tick();
        buttons(0, 0, 0, 1, 0); tick();
        buttons(0, 0, 0, 0, 1); tick();
        chk("run_state", 32'(state_out), 32'(S_EXIT));
        chk("run_flag", 32'(run), 32'd1);
        chk("run_xp", 32'(xp_out), 32'd33);
        chk("run_enemy", 32'(enemy_health), 32'd100);

        phase = "conflict";
        buttons(0, 0, 0, 0, 0);
        begin_battle(8'd100, 8'd5);
        buttons(0, 1, 0, 1, 0); tick();
        chk("cursor_11", 32'({arrow_col, arrow_row}), 32'd3);
        buttons(1, 1, 1, 1, 0); tick();
        chk("cursor_conflict", 32'({arrow_col, arrow_row}), 32'd0);
        buttons(0, 0, 0, 0, 1);
        p = 0;
        repeat (10) begin
            tick();
            if (state_out == 3'(S_PATK)) p++;
        end
        chk("one_p_atk", 32'(p), 32'd1);

        phase = "abort";
        w = 0;
        while (!(m_state == S_EWAIT && m_cnt == 7) && w < 100) begin tick(); w++; end
        hp_hold = m_hp;
        start = 1'b0;
        step(1'b0);
        chk("abort_state", 32'(state_out), 32'(S_IDLE));
        chk("abort_health", 32'(health_out), 32'(hp_hold));
        buttons(0, 0, 0, 0, 0);
        health_in = 8'd90; xp_in = 8'd7; start = 1'b1;
        step(1'b0);
        chk("reload_health", 32'(health_out), 32'd90);
        chk("reload_enemy", 32'(enemy_health), 32'd100);
        tick();
        buttons(0, 0, 0, 0, 1); tick();
        buttons(0, 0, 0, 0, 0); tick();
        w = 0;
        while (state_out == 3'(S_EWAIT) && w < 100) begin w++; tick(); end
        chk("e_wait_ticks", 32'(w), 32'(EDELAY + 1));

        phase = "random";
        repeat (700) begin
            buttons(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 1) == 0));
            if (start && $urandom_range(0, 79) == 0) start = 1'b0;
            else if (!start && $urandom_range(0, 2) == 0) begin
                health_in = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                xp_in     = 8'($urandom);
                start     = 1'b1;
            end
            if ($urandom_range(0, 1) == 0) tick(); else step(1'b0);
        end

        phase = "async_reset";
        buttons(0, 0, 0, 0, 0);
        begin_battle(8'd100, 8'd10);
        buttons(1, 0, 1, 0, 1); tick();
        buttons(0, 0, 0, 0, 0);
        repeat (4) tick();
        #2 rst_n_in = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        start = 1'b0;
        step(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
